countdown_timer_ctrl: RTL

Parametrised countdown timer controller with N BCD digits.
- Two synchronized button levels drive it: a long-press entry into programming mode, per-digit editing with a flashing cursor, run/pause, reload, and an expiry state.
- It generates its own count tick and flicker timing from clk.
- Its outputs feed the existing 7-segment display driver.

---
 rtl/countdown_timer_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: N-digit BCD count/preset, two-button UI with long-press
// programming mode, flashing edit cursor, run/pause, reload and expiry.
module countdown_timer_ctrl #(
    parameter int DIGITS            = 4,
    parameter int TICK_DIV          = 50000000,
    parameter int LONG_PRESS_CYCLES = 250000000,
    parameter int FLICKER_DIV       = 12500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn1,
    input  logic                  btn2,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic                  mode_prog,
    output logic                  running,
    output logic                  expired
);

    localparam int BW     = 4 * DIGITS;
    localparam int CUR_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TDW    = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int FDW    = $clog2(FLICKER_DIV + 1);

    localparam logic [TDW-1:0]    TICK_LAST  = TDW'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [FDW-1:0]    FLICK_LAST = FDW'(FLICKER_DIV - 1);
    localparam logic [CUR_W-1:0]  CUR_LAST   = CUR_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PROG,
        ST_EXPIRED
    } state_t;

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Only called on a non-zero value, so the final borrow is never lost.
    function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [BW-1:0]       preset_q, preset_d;
    logic [BW-1:0]       count_q, count_d;
    logic [CUR_W-1:0]    cursor_q, cursor_d;
    logic                btn1_prev_q, btn2_prev_q;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                long_fired_q, long_fired_d;
    logic [TDW-1:0]      tdiv_q, tdiv_d;
    logic [FDW-1:0]      fdiv_q, fdiv_d;
    logic                phase_q, phase_d;

    logic [BW-1:0]       digits_q, digits_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                mode_prog_q, mode_prog_d;
    logic                running_q, running_d;
    logic                expired_q, expired_d;

    logic                btn1_fall, btn2_rise;
    logic                short_press, long_press, tick;
    logic [BW-1:0]       count_dec;

    // Button events: the long press fires once, the first cycle the hold counter sits at its ceiling.
    always_comb begin
        btn1_fall    = ~btn1 & btn1_prev_q;
        btn2_rise    = btn2 & ~btn2_prev_q;
        short_press  = btn1_fall & (hold_q != HOLD_MAX);
        long_press   = (hold_q == HOLD_MAX) & ~long_fired_q;
        hold_d       = '0;
        if (btn1) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
        long_fired_d = btn1 & (long_fired_q | long_press);
        tick         = (state_q == ST_RUN) && (tdiv_q == TICK_LAST);
        count_dec    = tick ? bcd_dec(count_q) : count_q;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_q;
        cursor_d = cursor_q;
        tdiv_d   = '0;
        fdiv_d   = '0;
        phase_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (short_press && (count_q != '0)) begin
                    state_d = ST_RUN;
                end else if (long_press) begin
                    state_d  = ST_PROG;
                    cursor_d = '0;
                end else if (btn2_rise) begin
                    count_d = preset_q;
                end
            end
            ST_RUN: begin
                count_d = count_dec;
                tdiv_d  = tick ? '0 : tdiv_q + 1'b1;
                if (short_press) begin
                    state_d = ST_IDLE;
                end else if (btn2_rise) begin
                    count_d = preset_q;
                    tdiv_d  = '0;
                    state_d = (preset_q == '0) ? ST_EXPIRED : ST_RUN;
                end else if (count_dec == '0) begin
                    state_d = ST_EXPIRED;
                end
            end
            ST_PROG: begin
                if (short_press) begin
                    cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + 1'b1;
                end else if (long_press) begin
                    count_d = preset_q;
                    state_d = ST_IDLE;
                end else if (btn2_rise) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (CUR_W'(i) == cursor_q) begin
                            preset_d[4*i +: 4] = digit_inc(preset_q[4*i +: 4]);
                        end
                    end
                end
            end
            ST_EXPIRED: begin
                if (short_press) begin
                    count_d = preset_q;
                    state_d = ST_IDLE;
                end else if (long_press) begin
                    state_d  = ST_PROG;
                    cursor_d = '0;
                end else if (btn2_rise) begin
                    count_d = preset_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_RUN) begin
            tdiv_d = '0;
        end

        // Blink restarts unblanked on every entry into PROG.
        if ((state_q == ST_PROG) && (state_d == ST_PROG)) begin
            if (fdiv_q == FLICK_LAST) begin
                fdiv_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fdiv_d  = fdiv_q + 1'b1;
                phase_d = phase_q;
            end
        end
    end

    always_comb begin
        digits_d    = (state_d == ST_PROG) ? preset_d : count_d;
        mode_prog_d = (state_d == ST_PROG);
        running_d   = (state_d == ST_RUN);
        expired_d   = (state_d == ST_EXPIRED);
        blank_d     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            blank_d[i] = mode_prog_d & phase_d & (CUR_W'(i) == cursor_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            preset_q     <= '0;
            count_q      <= '0;
            cursor_q     <= '0;
            hold_q       <= '0;
            long_fired_q <= 1'b0;
            tdiv_q       <= '0;
            fdiv_q       <= '0;
            phase_q      <= 1'b0;
            digits_q     <= '0;
            blank_q      <= '0;
            mode_prog_q  <= 1'b0;
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            preset_q     <= preset_d;
            count_q      <= count_d;
            cursor_q     <= cursor_d;
            hold_q       <= hold_d;
            long_fired_q <= long_fired_d;
            tdiv_q       <= tdiv_d;
            fdiv_q       <= fdiv_d;
            phase_q      <= phase_d;
            digits_q     <= digits_d;
            blank_q      <= blank_d;
            mode_prog_q  <= mode_prog_d;
            running_q    <= running_d;
            expired_q    <= expired_d;
        end
        // Tracking the level through reset means a button held across reset release gives no edge.
        btn1_prev_q <= btn1;
        btn2_prev_q <= btn2;
    end

    assign digits_out = digits_q;
    assign blank_out  = blank_q;
    assign mode_prog  = mode_prog_q;
    assign running    = running_q;
    assign expired    = expired_q;

endmodule
